// File: rtl/pid_out_pkg.sv
// Shared types and defaults for the pid_output_accum slice: FSM state enum,
// default geometry/clamp constants and the clamp(0) reset-value helper.
package pid_out_pkg;

  typedef enum logic [1:0] {IDLE, SUM, CLAMP, OUT} state_t;

  localparam int unsigned DEF_W        = 16;
  localparam int unsigned DEF_CH       = 4;
  localparam int unsigned DEF_CH_W     = 2;
  localparam int          DEF_U_MIN    = 0;
  localparam int          DEF_U_MAX    = 181;
  localparam int          DEF_SLEW_MAX = 32;

  // Zero pulled into [lo, hi]; used as the accumulator reset/clear value.
  function automatic int clamp_zero(input int lo, input int hi);
    if (lo > 0) return lo;
    if (hi < 0) return hi;
    return 0;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational saturating clamp: W+1-bit signed input squeezed into [LO, HI]
// as a W-bit value, with flags showing which bound was applied.
module sat_clamp #(
  parameter int unsigned W  = 16,
  parameter int          LO = 0,
  parameter int          HI = 181
) (
  input  logic signed [W:0]   din,
  output logic signed [W-1:0] dout,
  output logic                hi,
  output logic                lo
);

  localparam logic signed [W:0] LO_X = (W+1)'(LO);
  localparam logic signed [W:0] HI_X = (W+1)'(HI);

  always_comb begin
    hi   = din > HI_X;
    lo   = din < LO_X;
    dout = din[W-1:0];
    if (hi)      dout = HI_X[W-1:0];
    else if (lo) dout = LO_X[W-1:0];
  end

endmodule

// File: rtl/pid_output_accum.sv
// Multi-channel PID output integrator with anti-windup clamp and valid/ready output.
// Optional macro SLEW_LIMIT_EN limits each delta to +/-SLEW_MAX and adds slew_lim.
module pid_output_accum
  import pid_out_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned CH       = DEF_CH,
  parameter int unsigned CH_W     = DEF_CH_W,
  parameter int          U_MIN    = DEF_U_MIN,
  parameter int          U_MAX    = DEF_U_MAX,
  parameter int          SLEW_MAX = DEF_SLEW_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic signed [W-1:0] delta_u,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic signed [W-1:0] u_out,
  output logic                sat_hi,
  output logic                sat_lo
`ifdef SLEW_LIMIT_EN
  ,
  output logic                slew_lim
`endif
);

  localparam int unsigned NSLOT = 2**CH_W;
  localparam logic signed [W-1:0] ACC_RST = W'(clamp_zero(U_MIN, U_MAX));

  if (CH < 1 || CH > 16 || NSLOT < CH || U_MIN > U_MAX || SLEW_MAX <= 0) begin : g_param_check
    $error("pid_output_accum: illegal parameter set");
  end

  state_t state, state_nxt;

  // One slot per representable index so ch_q never addresses outside the array.
  logic signed [W-1:0] acc [NSLOT];
  logic [CH_W-1:0]     ch_q;
  logic signed [W-1:0] delta_q, delta_eff, acc_cur, v;
  logic signed [W:0]   sum_q, sum_nxt;
  logic                bad_q, v_hi, v_lo, accept;

`ifdef SLEW_LIMIT_EN
  logic slew_hi_hit, slew_lo_hit, slew_q;

  sat_clamp #(.W(W), .LO(-SLEW_MAX), .HI(SLEW_MAX)) u_slew_clamp (
    .din  ({delta_q[W-1], delta_q}),
    .dout (delta_eff),
    .hi   (slew_hi_hit),
    .lo   (slew_lo_hit)
  );
`else
  assign delta_eff = delta_q;
`endif

  assign acc_cur = acc[ch_q];
  assign sum_nxt = {acc_cur[W-1], acc_cur} + {delta_eff[W-1], delta_eff};

  sat_clamp #(.W(W), .LO(U_MIN), .HI(U_MAX)) u_sum_clamp (
    .din  (sum_q),
    .dout (v),
    .hi   (v_hi),
    .lo   (v_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) && !reset && !clr;
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (accept) state_nxt = SUM;
      SUM:     state_nxt = bad_q ? IDLE : CLAMP;
      CLAMP:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSLOT; i++) acc[i] <= ACC_RST;
      ch_q      <= '0;
      delta_q   <= '0;
      bad_q     <= 1'b0;
      sum_q     <= '0;
      u_out     <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
`ifdef SLEW_LIMIT_EN
      slew_q    <= 1'b0;
      slew_lim  <= 1'b0;
`endif
    end else if (clr) begin
      for (int unsigned i = 0; i < NSLOT; i++) acc[i] <= ACC_RST;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ch_q    <= in_ch;
          delta_q <= delta_u;
          bad_q   <= 32'(in_ch) >= CH;
        end
        SUM: begin
          sum_q  <= sum_nxt;
`ifdef SLEW_LIMIT_EN
          slew_q <= slew_hi_hit || slew_lo_hit;
`endif
        end
        CLAMP: begin
          acc[ch_q] <= v;
          u_out     <= v;
          out_ch    <= ch_q;
          sat_hi    <= v_hi;
          sat_lo    <= v_lo;
          out_valid <= 1'b1;
`ifdef SLEW_LIMIT_EN
          slew_lim  <= slew_q;
`endif
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
